i2c_imu_responder: RTL and testbench

I2C_IMU_RESPONDER -- requirements
Module: i2c_imu_responder

---
 rtl/i2c_imu_pkg.sv | 19 +
 rtl/i2c_bus_cond.sv | 37 +++
 rtl/i2c_imu_responder.sv | 174 +++++++++++++++++
 tb/tb_i2c_imu_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_imu_pkg.sv
// i2c_imu_pkg: FSM state codes, IMU register-map indices and synchronizer depth shared by the responder.
package i2c_imu_pkg;
    localparam int SYNC_DEPTH = 2;
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_REG       = 4'd3;
    localparam logic [3:0] S_REG_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_WAIT_STOP = 4'd9;
    localparam logic [7:0] IDX_ACCEL   = 8'h3B;
    localparam logic [7:0] IDX_TEMP    = 8'h41;
    localparam logic [7:0] IDX_GYRO    = 8'h43;
    localparam logic [7:0] IDX_LAST    = 8'h48;
    localparam logic [7:0] IDX_WHOAMI  = 8'h75;
endpackage

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond: synchronizes SCL/SDA and flags START, STOP and SCL edges from the synchronized values.
module i2c_bus_cond
    import i2c_imu_pkg::*;
(
    input  logic c50m,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic start_o,
    output logic stop_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_DEPTH-1:0] scl_q, sda_q;
    logic scl_h_q, sda_h_q, scl, sda;
    assign scl = scl_q[SYNC_DEPTH-1];
    assign sda = sda_q[SYNC_DEPTH-1];
    always_ff @(posedge c50m) begin
        if (rst) begin
            scl_q   <= '1;
            sda_q   <= '1;
            scl_h_q <= 1'b1;
            sda_h_q <= 1'b1;
        end else begin
            scl_q   <= {scl_q[SYNC_DEPTH-2:0], scl_i};
            sda_q   <= {sda_q[SYNC_DEPTH-2:0], sda_i};
            scl_h_q <= scl;
            sda_h_q <= sda;
        end
    end
    assign sda_o   = sda;
    assign start_o = scl & scl_h_q & sda_h_q & ~sda;
    assign stop_o  = scl & scl_h_q & ~sda_h_q & sda;
    assign rise_o  = scl & ~scl_h_q;
    assign fall_o  = ~scl & scl_h_q;
endmodule

// File: rtl/i2c_imu_responder.sv
// i2c_imu_responder: I2C target serving a tear-free snapshot of IMU sample words as a register map.
// Define I2C_RSP_WRITE_EN to ACK data writes and report them on WrStrobe/WrAddr/WrData.
module i2c_imu_responder
    import i2c_imu_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h68,
    parameter logic [7:0] WHO_AM_I    = 8'h68
) (
    input  logic        c50m,
    input  logic        rst,
    input  logic        I2C_SCL,
    inout  wire         I2C_SDA,
    input  logic [15:0] AccelX,
    input  logic [15:0] AccelY,
    input  logic [15:0] AccelZ,
    input  logic [15:0] Temp,
    input  logic [15:0] GyroX,
    input  logic [15:0] GyroY,
    input  logic [15:0] GyroZ,
    input  logic        SampleLoad,
    output logic        Busy,
    output logic        WrStrobe,
    output logic [7:0]  WrAddr,
    output logic [7:0]  WrData
);
    logic sda, start, stop, rise, fall, rx, match;
    logic [3:0] state_q, state_d, cnt_q, cnt_d, off;
    logic [7:0] sh_q, sh_d, ptr_q, ptr_d, rd_byte, wa_q, wa_d, wd_q, wd_d;
    logic oe_q, oe_d, busy_q, busy_d, rw_q, rw_d, nack_q, nack_d, stb_q, stb_d, pend_q;
    logic [6:0][15:0] shadow_q, pbuf_q, words;

    i2c_bus_cond u_cond (
        .c50m    (c50m),
        .rst     (rst),
        .scl_i   (I2C_SCL),
        .sda_i   (I2C_SDA),
        .sda_o   (sda),
        .start_o (start),
        .stop_o  (stop),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign I2C_SDA  = oe_q ? 1'b0 : 1'bz;
    assign Busy     = busy_q;
    assign WrStrobe = stb_q;
    assign WrAddr   = wa_q;
    assign WrData   = wd_q;
    assign words    = {GyroZ, GyroY, GyroX, Temp, AccelZ, AccelY, AccelX};
    // Sample words sit big-endian from 0x3B, so even offsets hold the high byte.
    assign off      = 4'(ptr_q - IDX_ACCEL);
    assign rd_byte  = (ptr_q >= IDX_ACCEL && ptr_q <= IDX_LAST)
                    ? (off[0] ? shadow_q[off[3:1]][7:0] : shadow_q[off[3:1]][15:8])
                    : (ptr_q == IDX_WHOAMI ? WHO_AM_I : 8'h00);
    assign rx       = state_q == S_ADDR || state_q == S_REG || state_q == S_WDATA;
    assign match    = sh_q[7:1] == TARGET_ADDR;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        ptr_d   = ptr_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        rw_d    = rw_q;
        nack_d  = nack_q;
        stb_d   = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        if (start) begin
            state_d = S_ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (rise) begin
            if ((rx || state_q == S_RDATA) && cnt_q != 4'd8) cnt_d = cnt_q + 4'd1;
            if (rx && cnt_q != 4'd8) sh_d = {sh_q[6:0], sda};
            if (state_q == S_RDATA_ACK) nack_d = sda;
        end else if (fall) begin
            // SDA only moves on SCL fall; ACK slots are held until the following fall.
            case (state_q)
                S_ADDR: if (cnt_q == 4'd8) begin
                    state_d = match ? S_ADDR_ACK : S_WAIT_STOP;
                    oe_d    = match;
                    busy_d  = busy_q | match;
                    rw_d    = sh_q[0];
                end
                S_ADDR_ACK: begin
                    state_d = rw_q ? S_RDATA : S_REG;
                    sh_d    = rd_byte;
                    oe_d    = rw_q & ~rd_byte[7];
                    cnt_d   = '0;
                end
                S_REG: if (cnt_q == 4'd8) begin
                    state_d = S_REG_ACK;
                    ptr_d   = sh_q;
                    oe_d    = 1'b1;
                end
                S_REG_ACK, S_WDATA_ACK: begin
                    state_d = S_WDATA;
                    oe_d    = 1'b0;
                    cnt_d   = '0;
                end
                S_WDATA: if (cnt_q == 4'd8) begin
`ifdef I2C_RSP_WRITE_EN
                    state_d = S_WDATA_ACK;
                    oe_d    = 1'b1;
                    stb_d   = 1'b1;
                    wa_d    = ptr_q;
                    wd_d    = sh_q;
                    ptr_d   = ptr_q + 8'd1;
`else
                    state_d = S_WAIT_STOP;
                    oe_d    = 1'b0;
`endif
                end
                S_RDATA: if (cnt_q == 4'd8) begin
                    state_d = S_RDATA_ACK;
                    oe_d    = 1'b0;
                    ptr_d   = ptr_q + 8'd1;
                end else begin
                    sh_d = {sh_q[6:0], 1'b0};
                    oe_d = ~sh_q[6];
                end
                S_RDATA_ACK: begin
                    state_d = nack_q ? S_WAIT_STOP : S_RDATA;
                    sh_d    = rd_byte;
                    oe_d    = ~nack_q & ~rd_byte[7];
                    cnt_d   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge c50m) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            ptr_q    <= '0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            rw_q     <= 1'b0;
            nack_q   <= 1'b0;
            stb_q    <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            shadow_q <= '0;
            pbuf_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ptr_q   <= ptr_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            rw_q    <= rw_d;
            nack_q  <= nack_d;
            stb_q   <= stb_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            // A load arriving mid-transfer is parked and applied once the bus is released.
            if (SampleLoad && !busy_q) shadow_q <= words;
            else if (pend_q && !busy_q) shadow_q <= pbuf_q;
            if (SampleLoad && busy_q) pbuf_q <= words;
            pend_q <= busy_q ? (pend_q | SampleLoad) : 1'b0;
        end
    end
endmodule

// File: tb/tb_i2c_imu_responder.sv
// tb_i2c_imu_responder: directed/random I2C initiator against an array model of the IMU register map.
// Write expectations follow I2C_RSP_WRITE_EN.
module tb_i2c_imu_responder;
    localparam logic [6:0] TA = 7'h68;
    logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_oe = 1'b0, load = 1'b0;
    logic [15:0] w [7];
    logic busy, wstb;
    logic [7:0] waddr, wdata;
    wire sda;
    int passed = 0, total = 0, q = 31, drv_cnt = 0, busy_cnt = 0;
    logic [7:0] img [256];
    logic [15:0] snap [7], pend_w [7];
    bit in_burst = 0, pend_m = 0;
    logic [15:0] stq [$];

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;
    always #10 clk = ~clk;

    i2c_imu_responder dut (
        .c50m       (clk),
        .rst        (rst),
        .I2C_SCL    (scl),
        .I2C_SDA    (sda),
        .AccelX     (w[0]),
        .AccelY     (w[1]),
        .AccelZ     (w[2]),
        .Temp       (w[3]),
        .GyroX      (w[4]),
        .GyroY      (w[5]),
        .GyroZ      (w[6]),
        .SampleLoad (load),
        .Busy       (busy),
        .WrStrobe   (wstb),
        .WrAddr     (waddr),
        .WrData     (wdata)
    );

    always @(negedge clk) begin
        if (wstb) stq.push_back({waddr, wdata});
        if (!m_oe && sda === 1'b0) drv_cnt++;
        if (busy) busy_cnt++;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void rebuild();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        for (int k = 0; k < 7; k++) begin
            img[8'h3B + 2 * k] = snap[k][15:8];
            img[8'h3C + 2 * k] = snap[k][7:0];
        end
        img[8'h75] = 8'h68;
    endfunction

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_words();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
        if (in_burst) begin
            pend_w = w;
            pend_m = 1;
        end else begin
            snap = w;
            rebuild();
        end
    endtask

    task automatic bus_start();
        m_oe = 1'b0; wq(q);
        scl = 1'b1;  wq(q);
        m_oe = 1'b1; wq(q);
        scl = 1'b0;  wq(q);
    endtask

    task automatic bus_stop();
        m_oe = 1'b1; wq(q);
        scl = 1'b1;  wq(q);
        m_oe = 1'b0; wq(2 * q);
    endtask

    task automatic write_bit(input logic b);
        m_oe = ~b; wq(q);
        scl = 1'b1; wq(2 * q);
        scl = 1'b0; wq(q);
    endtask

    task automatic read_bit(output logic b);
        m_oe = 1'b0; wq(q);
        scl = 1'b1; wq(q);
        b = sda; wq(q);
        scl = 1'b0; wq(q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    task automatic read_burst(input logic [7:0] r, input int n, input int load_at, input string tag);
        logic a;
        logic [7:0] d;
        bus_start();
        send_byte({TA, 1'b0}, a);
        chk({tag, "_aw_ack"}, a, 1);
        chk({tag, "_busy"}, busy, 1);
        send_byte(r, a);
        chk({tag, "_reg_ack"}, a, 1);
        bus_start();
        send_byte({TA, 1'b1}, a);
        chk({tag, "_ar_ack"}, a, 1);
        in_burst = 1;
        for (int i = 0; i < n; i++) begin
            if (i == load_at) begin
                for (int k = 0; k < 7; k++) w[k] = 16'($urandom);
                load_words();
            end
            recv_byte(d, i < n - 1);
            chk($sformatf("%s_byte%0d", tag, i), d, img[8'(int'(r) + i)]);
        end
        bus_stop();
        in_burst = 0;
        if (pend_m) begin
            snap = pend_w;
            rebuild();
            pend_m = 0;
        end
        chk({tag, "_busy_stop"}, busy, 0);
    endtask

    initial begin
        logic a, b;
        int base, d0, b0;
        for (int k = 0; k < 7; k++) begin
            w[k] = '0;
            snap[k] = '0;
        end
        rebuild();
        wq(5);
        rst = 1'b0;
        wq(2);
        chk("rst_busy", busy, 0);
        chk("rst_wstb", wstb, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_sda", sda, 1);

        q = 125;
        read_burst(8'h75, 1, -1, "who_100k");
        q = 31;
        read_burst(8'h75, 1, -1, "who_400k");

        for (int k = 0; k < 7; k++) w[k] = 16'($urandom);
        w[0] = 16'h1234;
        load_words();
        read_burst(8'h3B, 2, -1, "accx");
        read_burst(8'h50, 1, -1, "unmapped");

        d0 = drv_cnt;
        b0 = busy_cnt;
        bus_start();
        send_byte({7'h69, 1'b0}, a);
        chk("badaddr_nack", a, 0);
        bus_stop();
        chk("badaddr_drive", 16'(drv_cnt - d0), 0);
        chk("badaddr_busy", 16'(busy_cnt - b0), 0);

        base = stq.size();
        bus_start();
        send_byte({TA, 1'b0}, a);
        chk("wr_aw_ack", a, 1);
        send_byte(8'h6B, a);
        chk("wr_reg_ack", a, 1);
        send_byte(8'h00, a);
`ifdef I2C_RSP_WRITE_EN
        chk("wr_d0_ack", a, 1);
        send_byte(8'h01, a);
        chk("wr_d1_ack", a, 1);
        bus_stop();
        chk("wr_count", 16'(stq.size() - base), 2);
        chk("wr_first", stq[base], 16'h6B00);
        chk("wr_second", stq[base + 1], 16'h6C01);
`else
        chk("wr_d0_nack", a, 0);
        bus_stop();
        chk("wr_count", 16'(stq.size() - base), 0);
        chk("wr_addr_tied", waddr, 0);
        chk("wr_data_tied", wdata, 0);
`endif

        for (int k = 0; k < 7; k++) w[k] = 16'($urandom);
        load_words();
        read_burst(8'h3B, 14, 7, "burst");
        read_burst(8'h45, 4, -1, "newgyro");

        bus_start();
        send_byte({TA, 1'b0}, a);
        chk("rst_aw_ack", a, 1);
        send_byte(8'hFF, a);
        chk("rst_reg_ack", a, 1);
        bus_start();
        send_byte({TA, 1'b1}, a);
        chk("rst_ar_ack", a, 1);
        for (int i = 0; i < 3; i++) read_bit(b);
        m_oe = 1'b0; wq(q);
        scl = 1'b1; wq(q);
        chk("rst_bit4_driven", sda, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("rst_sda_released", sda, 1);
        rst = 1'b0;
        wq(1);
        chk("rst_mid_busy", busy, 0);
        for (int k = 0; k < 7; k++) snap[k] = '0;
        rebuild();
        pend_m = 0;
        scl = 1'b0; wq(q);
        bus_stop();
        read_burst(8'hFF, 2, -1, "wrap");
        read_burst(8'h3B, 1, -1, "cleared");
`ifdef I2C_RSP_WRITE_EN
        base = stq.size();
        bus_start();
        send_byte({TA, 1'b0}, a);
        send_byte(8'hFF, a);
        send_byte(8'hA5, a);
        send_byte(8'h5A, a);
        bus_stop();
        chk("wrwrap_count", 16'(stq.size() - base), 2);
        chk("wrwrap_first", stq[base], 16'hFFA5);
        chk("wrwrap_second", stq[base + 1], 16'h005A);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
